// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with single-cycle handling of divide special cases.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            reg_wr_en
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [2:0]      op;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] opnd;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] res;

   logic            a_signed, b_signed, a_neg, b_neg, is_div, special;
   logic [XLEN-1:0] abs_a, abs_b, special_res;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            div_ge;
   logic [2*XLEN-1:0] mul_next, div_next, next_prod, mul_p;
   logic [XLEN-1:0] quo, rem, final_res;

   // Operand conditioning and special-case detection for the accept edge
   always_comb begin
      is_div   = funct3[2];
      a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
      b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg    = a_signed && rs1_data[XLEN-1];
      b_neg    = b_signed && rs2_data[XLEN-1];
      abs_a    = a_neg ? -rs1_data : rs1_data;
      abs_b    = b_neg ? -rs2_data : rs2_data;
      special     = 1'b0;
      special_res = '0;
      if (is_div && (rs2_data == '0)) begin
         special     = 1'b1;
         special_res = funct3[1] ? rs1_data : '1;
      end else if (is_div && !funct3[0] && (rs2_data == '1) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}})) begin
         special     = 1'b1;
         special_res = funct3[1] ? '0 : rs1_data;
      end
   end

   // One iteration of either algorithm plus final sign fix-up of the result.
   // prod holds {partial, multiplier} when multiplying and {remainder, quotient}
   // when dividing, so a single register shifts in both directions.
   always_comb begin
      mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, prod[XLEN-1:1]};
      div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      div_ge    = div_shift >= {1'b0, opnd};
      div_diff  = div_shift - {1'b0, opnd};
      div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                   prod[XLEN-2:0], div_ge};
      next_prod = op[2] ? div_next : mul_next;
      mul_p     = neg_q ? -next_prod : next_prod;
      quo       = next_prod[XLEN-1:0];
      rem       = next_prod[2*XLEN-1:XLEN];
      if (!op[2])
         final_res = (op[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
      else if (!op[1])
         final_res = neg_q ? -quo : quo;
      else
         final_res = neg_r ? -rem : rem;
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op     <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         opnd   <= '0;
         prod   <= '0;
         cnt    <= '0;
         res    <= '0;
         rd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && !kill) begin
                  op     <= funct3;
                  rd_out <= rd_in;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  cnt    <= '0;
                  if (special) begin
                     res   <= special_res;
                     state <= DONE;
                  end else begin
                     state <= CALC;
                     if (is_div) begin
                        prod <= {{XLEN{1'b0}}, abs_a};
                        opnd <= abs_b;
                     end else begin
                        prod <= {{XLEN{1'b0}}, abs_b};
                        opnd <= abs_a;
                     end
                  end
               end
            end
            CALC: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  prod <= next_prod;
                  cnt  <= cnt + 1'b1;
                  if (cnt == CW'(XLEN-1)) begin
                     res   <= final_res;
                     state <= DONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode; kill gates the result pulse in the same cycle
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE) && !kill;
      result    = done ? res : '0;
      reg_wr_en = done && (rd_out != '0);
   end

endmodule
